seq_calculator: RTL

SEQ_CALCULATOR -- requirements
Module: seq_calculator

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_divider.sv | 63 ++++++
 rtl/seq_calculator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the sequential calculator.
//   op_e    : operator encodings carried on i_selOperator.
//   state_e : control FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/calc_divider.sv
// calc_divider: restoring-division datapath, one quotient bit per step.
//   clk, srst : clock and synchronous active-high reset
//   load      : capture dividend/divisor and clear the partial remainder
//   step      : perform one restoring iteration
//   dividend, divisor : WIDTH-bit unsigned operands (divisor must be nonzero)
//   quotient, remainder : values produced by the step taken this cycle, so
//     the caller can register the final answer on the same edge as the last
//     iteration.
module calc_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // quo_q starts as the dividend and is shifted out MSB-first while the
  // quotient bits are shifted in from the LSB side.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    // A set MSB means the subtraction went negative: restore.
    if (trial[WIDTH]) begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle unsigned add/sub/mul/div unit.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_start          : request; accepted only in IDLE
//   i_a, i_b         : WIDTH-bit unsigned operands
//   i_selOperator    : 00 add, 01 sub, 10 mul, 11 div
//   o_busy           : high in CALC and DONE
//   o_done           : one-cycle pulse while in DONE
//   o_result         : 2*WIDTH-bit result
//   o_remainder      : division remainder (0 for other ops)
//   o_carry          : add carry-out / sub borrow
//   o_divByZero      : last operation was a divide by zero
// Add/sub/div-by-zero complete straight into DONE; mul (shift-add) and
// div (restoring) take WIDTH iterations in CALC. Result registers only
// change on entry to DONE.
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [1:0]         i_selOperator,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_result,
  output logic [WIDTH-1:0]   o_remainder,
  output logic               o_carry,
  output logic               o_divByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               carry_q, carry_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step;
  logic               div_load;
  logic               div_step;
  logic [WIDTH-1:0]   div_quotient;
  logic [WIDTH-1:0]   div_remainder;

  assign sum       = {1'b0, i_a} + {1'b0, i_b};
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  assign div_load = (state_q == IDLE) && i_start && (op_e'(i_selOperator) == OP_DIV) && (i_b != '0);
  assign div_step = (state_q == CALC) && (op_q == OP_DIV);

  calc_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (i_clk),
    .srst      (i_reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (i_a),
    .divisor   (i_b),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    result_d = result_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d  = op_e'(i_selOperator);
          cnt_d = '0;
          case (op_e'(i_selOperator))
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum};
              rem_d    = '0;
              carry_d  = sum[WIDTH];
              dbz_d    = 1'b0;
              state_d  = DONE;
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, i_a - i_b};
              rem_d    = '0;
              carry_d  = (i_a < i_b);
              dbz_d    = 1'b0;
              state_d  = DONE;
            end
            OP_MUL: begin
              mcand_d  = {{WIDTH{1'b0}}, i_a};
              mplier_d = i_b;
              prod_d   = '0;
              state_d  = CALC;
            end
            default: begin
              if (i_b == '0) begin
                result_d = '0;
                rem_d    = '0;
                carry_d  = 1'b0;
                dbz_d    = 1'b1;
                state_d  = DONE;
              end else begin
                state_d  = CALC;
              end
            end
          endcase
        end
      end

      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        // The WIDTH-th iteration happens on this edge; capture its outcome
        // directly rather than waiting a cycle for the datapath registers.
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          cnt_d   = '0;
          carry_d = 1'b0;
          dbz_d   = 1'b0;
          if (op_q == OP_MUL) begin
            result_d = prod_step;
            rem_d    = '0;
          end else begin
            result_d = {{WIDTH{1'b0}}, div_quotient};
            rem_d    = div_remainder;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      dbz_q    <= dbz_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);
  assign o_result    = result_q;
  assign o_remainder = rem_q;
  assign o_carry     = carry_q;
  assign o_divByZero = dbz_q;

endmodule
